// File: rtl/poly_sound_generator_pkg.sv
// Shared definitions for the poly_sound_generator voices: channel FSM encoding
// and the layout of a song ROM word {ticks, duration}.
package poly_sound_generator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_PLAY  = 3'd3,
    ST_DONE  = 3'd4
  } ch_state_t;

  // Duration sits in the low bits of a note word, ticks directly above it.
  localparam int DUR_LSB    = 0;
  localparam int END_MARKER = 0;  // duration value that terminates a song
  localparam int REST       = 0;  // ticks value that keeps the voice silent

  function automatic int ticks_lsb(input int dur_w);
    return DUR_LSB + dur_w;
  endfunction

endpackage

// File: rtl/poly_sound_generator_sound_channel.sv
// One voice: walks its song ROM, times each note in tempo beats and
// produces a square wave whose half-period is the note's tick count.
module sound_channel
  import poly_sound_generator_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int TICK_W = 18,
  parameter int DUR_W  = 3
) (
  input  logic                    clk,
  input  logic                    clr_n,
  input  logic                    play,
  input  logic                    start,
  input  logic                    loop,
  input  logic                    beat,
  input  logic [TICK_W+DUR_W-1:0] note_data,
  output logic [ADDR_W-1:0]       addr,
  output logic                    sound,
  output logic                    done,
  output ch_state_t               state
);

  localparam int TICK_LSB = ticks_lsb(DUR_W);

  logic [TICK_W-1:0] word_ticks;
  logic [DUR_W-1:0]  word_dur;
  logic [TICK_W-1:0] ticks;
  logic [TICK_W-1:0] tone_cnt;
  logic [DUR_W-1:0]  dur_cnt;

  // ROM handshake: addr is held stable through FETCH and note_data is
  // treated as valid only on the clock edge that ends WAIT.
  assign word_ticks = note_data[TICK_LSB +: TICK_W];
  assign word_dur   = note_data[DUR_LSB +: DUR_W];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= ST_IDLE;
      addr     <= '0;
      ticks    <= '0;
      tone_cnt <= '0;
      dur_cnt  <= '0;
      sound    <= 1'b0;
      done     <= 1'b0;
    end else if (start) begin
      state    <= ST_FETCH;
      addr     <= '0;
      tone_cnt <= '0;
      sound    <= 1'b0;
      done     <= 1'b0;
    end else if (!play) begin
      // Paused: everything holds except the tone phase, which restarts low.
      sound    <= 1'b0;
      tone_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE:  state <= ST_FETCH;
        ST_FETCH: state <= ST_WAIT;
        ST_WAIT: begin
          if (word_dur == DUR_W'(END_MARKER)) begin
            if (loop) begin
              addr  <= '0;
              state <= ST_FETCH;
            end else begin
              done  <= 1'b1;
              sound <= 1'b0;
              state <= ST_DONE;
            end
          end else begin
            ticks    <= word_ticks;
            dur_cnt  <= word_dur;
            tone_cnt <= '0;
            sound    <= 1'b0;
            state    <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (beat && dur_cnt == DUR_W'(1)) begin
            addr     <= addr + ADDR_W'(1);
            sound    <= 1'b0;
            tone_cnt <= '0;
            state    <= ST_FETCH;
          end else begin
            if (beat) dur_cnt <= dur_cnt - DUR_W'(1);
            if (ticks != TICK_W'(REST)) begin
              if (tone_cnt == ticks - TICK_W'(1)) begin
                tone_cnt <= '0;
                sound    <= ~sound;
              end else begin
                tone_cnt <= tone_cnt + TICK_W'(1);
              end
            end
          end
        end
        ST_DONE:  state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/poly_sound_generator.sv
// Multi-voice tone sequencer: shared tempo divider plus NUM_CH independent
// sound_channel voices, each reading its own slice of the song ROM bus.
module poly_sound_generator
  import poly_sound_generator_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 8,
  parameter int TICK_W   = 18,
  parameter int DUR_W    = 3,
  parameter int BEAT_DIV = 6250000
) (
  input  logic                             clk,
  input  logic                             clr_n,
  input  logic                             play,
  input  logic                             start,
  input  logic                             loop,
  output logic [NUM_CH*ADDR_W-1:0]         note_addr,
  input  logic [NUM_CH*(TICK_W+DUR_W)-1:0] note_data,
  output logic [NUM_CH-1:0]                sound,
  output logic [NUM_CH-1:0]                done,
  output logic                             beat,
  output logic [NUM_CH-1:0][2:0]           dbg_state
);

  localparam int NOTE_W = TICK_W + DUR_W;
  localparam int BEAT_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_DIV - 1);

  logic [BEAT_W-1:0] beat_cnt;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      beat_cnt <= '0;
    end else if (start) begin
      beat_cnt <= '0;
    end else if (play) begin
      beat_cnt <= (beat_cnt == BEAT_LAST) ? '0 : beat_cnt + BEAT_W'(1);
    end
  end

  // Strobe marks the wrap cycle; it is silent while paused or restarting.
  assign beat = play & ~start & (beat_cnt == BEAT_LAST);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    sound_channel #(
      .ADDR_W (ADDR_W),
      .TICK_W (TICK_W),
      .DUR_W  (DUR_W)
    ) u_ch (
      .clk       (clk),
      .clr_n     (clr_n),
      .play      (play),
      .start     (start),
      .loop      (loop),
      .beat      (beat),
      .note_data (note_data[k*NOTE_W +: NOTE_W]),
      .addr      (note_addr[k*ADDR_W +: ADDR_W]),
      .sound     (sound[k]),
      .done      (done[k]),
      .state     (dbg_state[k])
    );
  end

endmodule

// File: tb/tb_poly_sound_generator.sv
// Bench for poly_sound_generator: per-channel event scoreboard on sound,
// note_addr and done transitions, plus direct checks for reset and pause.
module tb_poly_sound_generator;
  import poly_sound_generator_pkg::*;

  localparam int NUM_CH   = 2;
  localparam int ADDR_W   = 8;
  localparam int TICK_W   = 18;
  localparam int DUR_W    = 3;
  localparam int BEAT_DIV = 10;
  localparam int NW       = TICK_W + DUR_W;
  localparam int EW       = 22;  // {kind[1:0], value[7:0], cycles since previous event[11:0]}
  localparam logic [1:0] EV_SND = 2'd1, EV_ADDR = 2'd2, EV_DONE = 2'd3;

  logic                      clk = 1'b0;
  logic                      clr_n, play, start, loop;
  logic [NUM_CH*ADDR_W-1:0]  note_addr;
  logic [NUM_CH*NW-1:0]      note_data = '0;
  logic [NUM_CH-1:0]         sound, done;
  logic                      beat;
  logic [NUM_CH-1:0][2:0]    dbg_state;

  logic [NW-1:0] rom [NUM_CH][4];
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  int cyc = 0, mark = 0, beat_cnt = 0, beat_base = 0;
  int n_cmp = 0, n_err = 0;
  int last_evt [NUM_CH];
  bit mon_en = 1'b0;
  logic [NUM_CH-1:0] p_snd = '0, p_done = '0;
  logic [ADDR_W-1:0] p_addr [NUM_CH];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  poly_sound_generator #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .TICK_W(TICK_W), .DUR_W(DUR_W), .BEAT_DIV(BEAT_DIV)
  ) dut (
    .clk(clk), .clr_n(clr_n), .play(play), .start(start), .loop(loop),
    .note_addr(note_addr), .note_data(note_data), .sound(sound), .done(done),
    .beat(beat), .dbg_state(dbg_state)
  );

  function automatic logic [NW-1:0] rom_rd(input int k, input logic [ADDR_W-1:0] a);
    return (a < ADDR_W'(4)) ? rom[k][a[1:0]] : '0;
  endfunction

  function automatic logic [NW-1:0] nw(input int t, input int d);
    return {TICK_W'(t), DUR_W'(d)};
  endfunction

  // Synchronous song ROMs: data valid one cycle after the address.
  always @(posedge clk)
    for (int k = 0; k < NUM_CH; k++)
      note_data[k*NW +: NW] <= rom_rd(k, note_addr[k*ADDR_W +: ADDR_W]);

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic push(input int ch, input logic [1:0] kind, input int val, input int dt);
    if (ch == 0) exp_q0.push_back({kind, 8'(val), 12'(dt)});
    else         exp_q1.push_back({kind, 8'(val), 12'(dt)});
  endtask

  task automatic see(input int ch, input logic [1:0] kind, input int val);
    logic [EW-1:0] got, want;
    int base;
    base = (last_evt[ch] > mark) ? last_evt[ch] : mark;
    got  = {kind, 8'(val), 12'(cyc - base)};
    last_evt[ch] = cyc;
    n_cmp++;
    if ((ch == 0 && exp_q0.size() == 0) || (ch == 1 && exp_q1.size() == 0)) begin
      n_err++;
      $display("FAIL evt_ch%0d unexpected: got kind=%0d val=%0d dt=%0d, expected no event",
               ch, got[21:20], got[19:12], got[11:0]);
    end else begin
      want = (ch == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      if (got !== want) begin
        n_err++;
        $display("FAIL evt_ch%0d at cycle %0d: got kind=%0d val=%0d dt=%0d, expected kind=%0d val=%0d dt=%0d",
                 ch, cyc, got[21:20], got[19:12], got[11:0], want[21:20], want[19:12], want[11:0]);
      end
    end
  endtask

  // Monitor: every transition of sound/note_addr/done is an event to match.
  always @(negedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (mon_en) begin
        if (sound[k] !== p_snd[k]) see(k, EV_SND, int'(sound[k]));
        if (note_addr[k*ADDR_W +: ADDR_W] !== p_addr[k])
          see(k, EV_ADDR, int'(note_addr[k*ADDR_W +: ADDR_W]));
        if (done[k] !== p_done[k]) see(k, EV_DONE, int'(done[k]));
      end
      p_snd[k]  = sound[k];
      p_done[k] = done[k];
      p_addr[k] = note_addr[k*ADDR_W +: ADDR_W];
    end
    if (beat) beat_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic do_start();
    start = 1'b1;
    play  = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    mark      = cyc;
    beat_base = beat_cnt;
  endtask

  task automatic step_to(input int k);
    while (cyc < mark + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic end_phase(input string name);
    check({name, "_q0_left"}, exp_q0.size(), 0);
    check({name, "_q1_left"}, exp_q1.size(), 0);
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic check_done_states(input string name);
    check({name, "_state0"}, int'(dbg_state[0]), int'(ST_DONE));
    check({name, "_state1"}, int'(dbg_state[1]), int'(ST_DONE));
  endtask

  task automatic load_rom(input int ch, input logic [NW-1:0] w0, input logic [NW-1:0] w1,
                          input logic [NW-1:0] w2);
    rom[ch][0] = w0; rom[ch][1] = w1; rom[ch][2] = w2; rom[ch][3] = '0;
  endtask

  // {ticks=3,dur=2} then end marker, measured from the start pulse.
  task automatic push_note32(input int ch);
    push(ch, EV_SND, 1, 5); push(ch, EV_SND, 0, 3); push(ch, EV_SND, 1, 3);
    push(ch, EV_SND, 0, 3); push(ch, EV_SND, 1, 3); push(ch, EV_SND, 0, 3);
    push(ch, EV_ADDR, 1, 0); push(ch, EV_DONE, 1, 2);
  endtask

  // {ticks=7,dur=1} then end marker.
  task automatic push_note71(input int ch);
    push(ch, EV_SND, 1, 9); push(ch, EV_SND, 0, 1);
    push(ch, EV_ADDR, 1, 0); push(ch, EV_DONE, 1, 2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clr_n = 1'b1; play = 1'b0; start = 1'b0; loop = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      last_evt[k] = 0;
      p_addr[k]   = '0;
      for (int i = 0; i < 4; i++) rom[k][i] = '0;
    end
    #1 clr_n = 1'b0;
    #1;
    check("rst_addr",  int'(note_addr), 0);
    check("rst_sound", int'(sound), 0);
    check("rst_done",  int'(done), 0);
    check("rst_beat",  int'(beat), 0);
    check("rst_state", int'(dbg_state[0]), int'(ST_IDLE));
    repeat (2) @(posedge clk);
    @(negedge clk) clr_n = 1'b1;
    @(posedge clk);
    #1 mon_en = 1'b1;

    // One-shot note: ticks=3 for two beats, then end marker.
    load_rom(0, nw(3, 2), nw(0, 0), nw(0, 0));
    push_note32(0);
    push(1, EV_DONE, 1, 2);
    do_start();
    step_to(30);
    end_phase("oneshot");
    check_done_states("oneshot");

    // Rest for one beat, then ticks=4 for one beat.
    load_rom(0, nw(0, 1), nw(4, 1), nw(0, 0));
    push(0, EV_ADDR, 0, 0); push(0, EV_DONE, 0, 0);
    push(0, EV_ADDR, 1, 10); push(0, EV_SND, 1, 6); push(0, EV_SND, 0, 4);
    push(0, EV_ADDR, 2, 0); push(0, EV_DONE, 1, 2);
    push(1, EV_DONE, 0, 0); push(1, EV_DONE, 1, 2);
    do_start();
    step_to(30);
    end_phase("rest");

    // Loop mode, then loop dropped mid-song: taken at the next end marker.
    loop = 1'b1;
    push(0, EV_ADDR, 0, 0); push(0, EV_DONE, 0, 0);
    push(0, EV_ADDR, 1, 10);
    for (int r = 0; r < 3; r++) begin
      push(0, EV_SND, 1, 6); push(0, EV_SND, 0, 4); push(0, EV_ADDR, 2, 0);
      if (r < 2) begin
        push(0, EV_ADDR, 0, 2); push(0, EV_ADDR, 1, 8);
      end
    end
    push(0, EV_DONE, 1, 2);
    push(1, EV_DONE, 0, 0); push(1, EV_DONE, 1, 46);
    do_start();
    step_to(45);
    loop = 1'b0;
    step_to(70);
    end_phase("loop");
    check_done_states("loop");

    // Pause for 25 cycles mid-note; remaining duration survives.
    load_rom(0, nw(3, 2), nw(0, 0), nw(0, 0));
    push(0, EV_ADDR, 0, 0); push(0, EV_DONE, 0, 0);
    push(0, EV_SND, 1, 5); push(0, EV_SND, 0, 3); push(0, EV_SND, 1, 3);
    push(0, EV_SND, 0, 2); push(0, EV_SND, 1, 27); push(0, EV_SND, 0, 3);
    push(0, EV_ADDR, 1, 2); push(0, EV_DONE, 1, 2);
    push(1, EV_DONE, 0, 0); push(1, EV_DONE, 1, 2);
    do_start();
    step_to(12);
    play = 1'b0;
    step_to(25);
    check("pause_sound", int'(sound[0]), 0);
    check("pause_addr",  int'(note_addr[ADDR_W-1:0]), 0);
    check("pause_beat",  int'(beat), 0);
    check("pause_state", int'(dbg_state[0]), int'(ST_PLAY));
    check("pause_beats", beat_cnt - beat_base, 1);
    step_to(37);
    check("pause_beats_end", beat_cnt - beat_base, 1);
    play = 1'b1;
    step_to(47);
    check("resume_beats", beat_cnt - beat_base, 2);
    step_to(55);
    end_phase("pause");

    // Two voices with different pitch and length.
    load_rom(1, nw(7, 1), nw(0, 0), nw(0, 0));
    push(0, EV_ADDR, 0, 0); push(0, EV_DONE, 0, 0); push_note32(0);
    push(1, EV_DONE, 0, 0); push_note71(1);
    do_start();
    step_to(30);
    end_phase("twoch");
    check_done_states("twoch");

    // Restart both voices mid-song.
    push(0, EV_ADDR, 0, 0); push(0, EV_DONE, 0, 0);
    push(0, EV_SND, 1, 5); push(0, EV_SND, 0, 3); push(0, EV_SND, 1, 3);
    push(0, EV_SND, 0, 0); push_note32(0);
    push(1, EV_ADDR, 0, 0); push(1, EV_DONE, 0, 0);
    push(1, EV_SND, 1, 9); push(1, EV_SND, 0, 1); push(1, EV_ADDR, 1, 0);
    push(1, EV_ADDR, 0, 0); push_note71(1);
    do_start();
    step_to(11);
    do_start();
    @(negedge clk);
    check("restart_addr", int'(note_addr), 0);
    check("restart_done", int'(done), 0);
    step_to(30);
    end_phase("restart");

    // Asynchronous reset in the middle of a ticks=5 note.
    load_rom(0, nw(5, 3), nw(0, 0), nw(0, 0));
    load_rom(1, nw(0, 0), nw(0, 0), nw(0, 0));
    push(0, EV_ADDR, 0, 0); push(0, EV_DONE, 0, 0); push(0, EV_SND, 1, 7);
    push(1, EV_ADDR, 0, 0); push(1, EV_DONE, 0, 0); push(1, EV_DONE, 1, 2);
    do_start();
    step_to(8);
    end_phase("prereset");
    mon_en = 1'b0;
    check("prereset_sound", int'(sound[0]), 1);
    clr_n = 1'b0;
    #1;
    check("midrst_sound", int'(sound), 0);
    check("midrst_done",  int'(done), 0);
    check("midrst_addr",  int'(note_addr), 0);
    check("midrst_beat",  int'(beat), 0);
    @(negedge clk) clr_n = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("postrst_low", int'(sound[0]), 0);
    @(posedge clk);
    @(negedge clk);
    check("postrst_high", int'(sound[0]), 1);
    check("postrst_addr", int'(note_addr[ADDR_W-1:0]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/poly_sound_generator.md
Name: poly_sound_generator

Overview:
- Parametrised multi-voice tone sequencer; generalises the fixed melody and bass pair to NUM_CH independent voices.
- Each voice fetches note words from an external synchronous song ROM, holds each note for a duration counted in tempo beats, and emits a square wave whose half-period is given in clock ticks.
- Adds rest notes, end-of-song markers, loop/one-shot mode, pause, restart and per-channel done flags.
- Sits between the song ROMs and the audio output pins.

Parameters:
- NUM_CH, 2, number of voices.
- ADDR_W, 8, song ROM address width per channel.
- TICK_W, 18, half-period width in clk cycles.
- DUR_W, 3, duration width in beats.
- BEAT_DIV, 6250000, clk cycles per tempo beat (≥2).

Ports:
- clk  in  1  system clock
- clr_n  in  1  asynchronous active-low reset
- play  in  1  1 = run, 0 = pause all voices
- start  in  1  single-cycle pulse: restart all voices at address 0
- loop  in  1  1 = wrap at end marker, 0 = stop
- note_addr  out  NUM_CH*ADDR_W  per-channel ROM address; channel k in slice k
- note_data  in  NUM_CH*(TICK_W+DUR_W)  per-channel ROM word {ticks, duration}, valid 1 cycle after address
- sound  out  NUM_CH  per-channel square wave
- done  out  NUM_CH  per-channel song finished (one-shot mode)
- beat  out  1  tempo strobe, 1 cycle wide

Behaviour:
- Reset (clr_n=0, async) forces:
  - note_addr=0, sound=0, done=0, beat=0;
  - beat counter=0, all channel FSMs in IDLE.
- Tempo: beat counter runs 0..BEAT_DIV-1 while play=1; beat=1 in the cycle the counter wraps. When play=0 the counter freezes and beat=0.
- Note word decoding:
  - ticks = upper TICK_W bits, duration = lower DUR_W bits.
  - duration=0 is the end marker.
  - ticks=0 is a rest: sound held 0 for the full duration.
- Channel FSM states: IDLE, FETCH, WAIT, PLAY, DONE.
  - IDLE → FETCH on start, or on play=1 after reset.
  - FETCH: drive note_addr, → WAIT.
  - WAIT: one cycle of ROM latency; latch note_data at the end of WAIT.
    - duration≠0: load dur_cnt=duration and tone_cnt=0, → PLAY.
    - duration=0 with loop=1: addr=0, → FETCH.
    - duration=0 with loop=0: → DONE, done=1, sound=0.
  - PLAY:
    - tone_cnt counts up each clk; at ticks-1 it resets to 0 and sound toggles. Resulting frequency = clk/(2*ticks).
    - On each beat, dur_cnt decrements. On the beat where dur_cnt==1: addr+1 (wraps modulo 2^ADDR_W), sound=0, → FETCH.
    - Note gap = 2 cycles (FETCH+WAIT), during which sound=0.
  - DONE: hold until start.
- Pause (play=0): all FSMs, counters and addresses freeze; sound forced 0. On play=1, resume exactly where frozen, tone phase restarting low.
- start has priority over every other condition:
  - next cycle: all channels addr=0, done=0, sound=0, → FETCH;
  - beat counter cleared.
- start while play=0: channels sit in FETCH frozen until play=1.
- Loop edge case: a whole song of end markers with loop=1 cycles FETCH/WAIT forever with no sound. This is permitted and must not hang the simulator.
- Loop toggling: loop is sampled only when the end marker is latched.
- Reset mid-note: immediate silence, then restart from address 0 after release with play=1.
- All channels share the beat strobe and are otherwise independent; they may finish at different times.

Decomposition:
- Shared package: FSM state encoding, note-word field offsets, END_MARKER and REST constants.
- One natural sub-module, sound_channel: FSM, duration counter, tone counter and address register. Instantiate it NUM_CH times with a generate loop.
- The top holds the beat divider and the start/play fan-out.

Test Plan:
- Reset with clr_n=0 mid-note (ticks=5) → sound=0, done=0, note_addr=0 immediately, with no clk edge.
- BEAT_DIV=10, ch0 ROM {ticks=3,dur=2},{0,0}, loop=0, play=1 → sound toggles every 3 clks for 2 beats, then done[0]=1 and sound[0]=0 thereafter.
- Rest: ROM {ticks=0,dur=1},{4,1},{0,0} → sound stays 0 for 1 beat, then period-8 square wave for 1 beat.
- Loop=1 with the same ROM → note_addr sequence 0,1,2,0,1,…; done never asserts.
- Pause: play=0 for 25 cycles mid-note → sound=0, note_addr and beat frozen; on resume, remaining duration is unchanged (check beat count).
- Two channels with different ticks (3, 7) and durations → independent frequencies and finish times. start pulse mid-song → both channels show addr=0 and done=0 on the next cycle.
